// File: rtl/parking_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : parking_pkg                                                 |
// | Purpose  : Lane state encoding and beam-sensor pair codes.             |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EN1,
        EN2,
        EN3,
        EX1,
        EX2,
        EX3,
        ERR
    } lane_state_t;

    // Sensor pair codes, written as {a, b}
    localparam logic [1:0] S_CLR = 2'b00;
    localparam logic [1:0] S_A   = 2'b10;
    localparam logic [1:0] S_AB  = 2'b11;
    localparam logic [1:0] S_B   = 2'b01;

endpackage
`default_nettype wire

// File: rtl/gate_direction_fsm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : gate_direction_fsm                                          |
// | Purpose  : One gate: sensor synchronisers and entry/exit direction FSM.|
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module gate_direction_fsm
    import parking_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_a,
    input  logic i_b,
    output logic o_entry,
    output logic o_exit,
    output logic o_err
);

    logic        r_a_meta;
    logic        r_a_sync;
    logic        r_b_meta;
    logic        r_b_sync;
    logic [1:0]  w_code;
    lane_state_t r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_meta <= 1'b0;
            r_a_sync <= 1'b0;
            r_b_meta <= 1'b0;
            r_b_sync <= 1'b0;
        end else begin
            r_a_meta <= i_a;
            r_a_sync <= r_a_meta;
            r_b_meta <= i_b;
            r_b_sync <= r_b_meta;
        end
    end

    assign w_code = {r_a_sync, r_b_sync};

    // Each state implies the code last seen, so a repeated code holds and
    // only the two neighbouring codes on the beam sequence are legal moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            o_entry <= 1'b0;
            o_exit  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_entry <= 1'b0;
            o_exit  <= 1'b0;
            o_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    case (w_code)
                        S_A:     r_state <= EN1;
                        S_B:     r_state <= EX1;
                        S_AB:    begin r_state <= ERR; o_err <= 1'b1; end
                        default: r_state <= IDLE;
                    endcase
                end
                EN1: begin
                    case (w_code)
                        S_AB:    r_state <= EN2;
                        S_CLR:   r_state <= IDLE;
                        S_B:     begin r_state <= ERR; o_err <= 1'b1; end
                        default: r_state <= EN1;
                    endcase
                end
                EN2: begin
                    case (w_code)
                        S_B:     r_state <= EN3;
                        S_A:     r_state <= EN1;
                        S_CLR:   begin r_state <= ERR; o_err <= 1'b1; end
                        default: r_state <= EN2;
                    endcase
                end
                EN3: begin
                    case (w_code)
                        S_CLR:   begin r_state <= IDLE; o_entry <= 1'b1; end
                        S_AB:    r_state <= EN2;
                        S_A:     begin r_state <= ERR; o_err <= 1'b1; end
                        default: r_state <= EN3;
                    endcase
                end
                EX1: begin
                    case (w_code)
                        S_AB:    r_state <= EX2;
                        S_CLR:   r_state <= IDLE;
                        S_A:     begin r_state <= ERR; o_err <= 1'b1; end
                        default: r_state <= EX1;
                    endcase
                end
                EX2: begin
                    case (w_code)
                        S_A:     r_state <= EX3;
                        S_B:     r_state <= EX1;
                        S_CLR:   begin r_state <= ERR; o_err <= 1'b1; end
                        default: r_state <= EX2;
                    endcase
                end
                EX3: begin
                    case (w_code)
                        S_CLR:   begin r_state <= IDLE; o_exit <= 1'b1; end
                        S_AB:    r_state <= EX2;
                        S_B:     begin r_state <= ERR; o_err <= 1'b1; end
                        default: r_state <= EX3;
                    endcase
                end
                ERR: begin
                    if (w_code == S_CLR) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/parking_lot_occupancy.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : parking_lot_occupancy                                       |
// | Purpose  : Multi-lane gate decoding with a clamped occupancy counter.  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module parking_lot_occupancy
    import parking_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int CAPACITY = 99,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic [LANES-1:0] A,
    input  logic [LANES-1:0] B,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [LANES-1:0] entry_pulse,
    output logic [LANES-1:0] exit_pulse,
    output logic [LANES-1:0] seq_err,
    output logic             ovf,
    output logic             unf
);

    // Four spare bits keep the signed sum exact for up to eight lanes
    localparam int                      c_nw      = CNT_W + 4;
    localparam logic signed [c_nw-1:0]  c_cap     = c_nw'(CAPACITY);
    localparam logic signed [c_nw-1:0]  c_one     = c_nw'(1);
    localparam logic [CNT_W-1:0]        c_cap_cnt = CNT_W'(CAPACITY);

    logic signed [c_nw-1:0] w_net;
    logic signed [c_nw-1:0] w_sum;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_ovf;
    logic                   w_unf;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gate_direction_fsm u_fsm (
            .clk     (CLK100MHZ),
            .rst     (reset),
            .i_a     (A[i]),
            .i_b     (B[i]),
            .o_entry (entry_pulse[i]),
            .o_exit  (exit_pulse[i]),
            .o_err   (seq_err[i])
        );
    end

    // All lanes are netted before clamping so opposite events cancel even at a limit
    always_comb begin
        w_net = '0;
        for (int i = 0; i < LANES; i++) begin
            if (entry_pulse[i]) w_net = w_net + c_one;
            if (exit_pulse[i])  w_net = w_net - c_one;
        end
        w_sum = $signed({4'b0000, count}) + w_net;
        w_ovf = (w_sum > c_cap);
        w_unf = w_sum[c_nw-1];
        if (w_ovf) begin
            w_count_next = c_cap_cnt;
        end else if (w_unf) begin
            w_count_next = '0;
        end else begin
            w_count_next = w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= w_count_next;
            full  <= (w_count_next == c_cap_cnt);
            empty <= (w_count_next == '0);
            ovf   <= w_ovf;
            unf   <= w_unf;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_occupancy.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_parking_lot_occupancy                                    |
// | Purpose  : Self-checking bench: vector table, model, corner sequences. |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_parking_lot_occupancy;

    localparam int LANES = 2;
    localparam int CAP_A = 99;
    localparam int CAP_B = 3;
    localparam int W_A   = $clog2(CAP_A + 1);
    localparam int W_B   = $clog2(CAP_B + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [LANES-1:0] a_in = '0;
    logic [LANES-1:0] b_in = '0;

    logic [W_A-1:0]   cnt_a;
    logic             full_a, empty_a, ovf_a, unf_a;
    logic [LANES-1:0] ent_a, ex_a, err_a;
    logic [W_B-1:0]   cnt_b;
    logic             full_b, empty_b, ovf_b, unf_b;
    logic [LANES-1:0] ent_b, ex_b, err_b;

    parking_lot_occupancy #(.LANES(LANES), .CAPACITY(CAP_A)) dut_a (
        .CLK100MHZ(clk), .reset(reset), .A(a_in), .B(b_in),
        .count(cnt_a), .full(full_a), .empty(empty_a),
        .entry_pulse(ent_a), .exit_pulse(ex_a), .seq_err(err_a),
        .ovf(ovf_a), .unf(unf_a)
    );

    parking_lot_occupancy #(.LANES(LANES), .CAPACITY(CAP_B)) dut_b (
        .CLK100MHZ(clk), .reset(reset), .A(a_in), .B(b_in),
        .count(cnt_b), .full(full_b), .empty(empty_b),
        .entry_pulse(ent_b), .exit_pulse(ex_b), .seq_err(err_b),
        .ovf(ovf_b), .unf(unf_b)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Reference model: a lane is a position along one of two beam paths
    int               m_dir [LANES];   // 0 none, 1 entering, 2 exiting, 3 error
    int               m_pos [LANES];
    logic [1:0]       m_s1  [LANES];
    logic [1:0]       m_s2  [LANES];
    logic [LANES-1:0] m_ent, m_ex, m_err;
    int               m_cnt [2];
    logic             m_ovf [2];
    logic             m_unf [2];
    int               caps  [2];

    function automatic logic [1:0] code_at(input int dir, input int pos);
        logic [1:0] ep [4];
        logic [1:0] xp [4];
        ep = '{2'b00, 2'b10, 2'b11, 2'b01};
        xp = '{2'b00, 2'b01, 2'b11, 2'b10};
        return (dir == 1) ? ep[pos] : xp[pos];
    endfunction

    task automatic lane_step(input int l, input logic [1:0] code,
                             output logic ent, output logic ex, output logic er);
        logic [1:0] cur, nxt, prv;
        ent = 1'b0; ex = 1'b0; er = 1'b0;
        if (m_dir[l] == 3) begin
            if (code == 2'b00) begin m_dir[l] = 0; m_pos[l] = 0; end
        end else begin
            cur = (m_dir[l] == 0) ? 2'b00 : code_at(m_dir[l], m_pos[l]);
            if (code != cur) begin
                if (m_dir[l] == 0) begin
                    if (code == 2'b10)      begin m_dir[l] = 1; m_pos[l] = 1; end
                    else if (code == 2'b01) begin m_dir[l] = 2; m_pos[l] = 1; end
                    else                    begin m_dir[l] = 3; er = 1'b1; end
                end else begin
                    nxt = code_at(m_dir[l], (m_pos[l] + 1) % 4);
                    prv = code_at(m_dir[l], m_pos[l] - 1);
                    if (code == nxt) begin
                        if (m_pos[l] == 3) begin
                            if (m_dir[l] == 1) ent = 1'b1; else ex = 1'b1;
                            m_dir[l] = 0; m_pos[l] = 0;
                        end else begin
                            m_pos[l]++;
                        end
                    end else if (code == prv) begin
                        m_pos[l]--;
                        if (m_pos[l] == 0) m_dir[l] = 0;
                    end else begin
                        m_dir[l] = 3; er = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_edge();
        logic [LANES-1:0] ne, nx, nr;
        logic e, x, r;
        int s;
        if (reset) begin
            for (int l = 0; l < LANES; l++) begin
                m_dir[l] = 0; m_pos[l] = 0; m_s1[l] = 2'b00; m_s2[l] = 2'b00;
            end
            m_ent = '0; m_ex = '0; m_err = '0;
            for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0; end
        end else begin
            for (int k = 0; k < 2; k++) begin
                s = m_cnt[k] + $countones(m_ent) - $countones(m_ex);
                m_ovf[k] = (s > caps[k]);
                m_unf[k] = (s < 0);
                m_cnt[k] = (s > caps[k]) ? caps[k] : ((s < 0) ? 0 : s);
            end
            for (int l = 0; l < LANES; l++) begin
                lane_step(l, m_s2[l], e, x, r);
                ne[l] = e; nx[l] = x; nr[l] = r;
                m_s2[l] = m_s1[l];
                m_s1[l] = {a_in[l], b_in[l]};
            end
            m_ent = ne; m_ex = nx; m_err = nr;
        end
    endtask

    function automatic logic [31:0] model_vec(input int k);
        return {6'b0, 16'(m_cnt[k]), (m_cnt[k] == caps[k]), (m_cnt[k] == 0),
                m_ovf[k], m_unf[k], m_ent, m_ex, m_err};
    endfunction

    logic [LANES-1:0] st_err_a, st_ent_a;
    logic             st_ovf_a, st_ovf_b, st_unf_a, st_unf_b;

    task automatic clear_sticky();
        st_err_a = '0; st_ent_a = '0;
        st_ovf_a = 1'b0; st_ovf_b = 1'b0; st_unf_a = 1'b0; st_unf_b = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_cap99", {6'b0, 16'(cnt_a), full_a, empty_a, ovf_a, unf_a, ent_a, ex_a, err_a},
              model_vec(0));
        check("model_cap3",  {6'b0, 16'(cnt_b), full_b, empty_b, ovf_b, unf_b, ent_b, ex_b, err_b},
              model_vec(1));
        st_err_a |= err_a; st_ent_a |= ent_a;
        st_ovf_a |= ovf_a; st_ovf_b |= ovf_b; st_unf_a |= unf_a; st_unf_b |= unf_b;
    endtask

    task automatic apply(input logic [1:0] a, input logic [1:0] b, input int n);
        a_in = a; b_in = b;
        repeat (n) step();
    endtask

    task automatic do_entry0();
        apply(2'b01, 2'b00, 1); apply(2'b01, 2'b01, 1); apply(2'b00, 2'b01, 1); apply(2'b00, 2'b00, 4);
    endtask

    task automatic do_exit0();
        apply(2'b00, 2'b01, 1); apply(2'b01, 2'b01, 1); apply(2'b01, 2'b00, 1); apply(2'b00, 2'b00, 4);
    endtask

    // Lane 0 enters while lane 1 exits, finishing on the same cycle
    task automatic do_both();
        apply(2'b01, 2'b10, 1); apply(2'b11, 2'b11, 1); apply(2'b10, 2'b01, 1); apply(2'b00, 2'b00, 4);
    endtask

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        int         cnt;
        logic [1:0] ent;
        logic [1:0] ex;
        logic [1:0] er;
    } vec_t;

    vec_t       vt [41];
    logic [1:0] ring [4];
    int         ri   [LANES];
    int         pref [LANES];
    int         rn;

    initial begin
        caps = '{CAP_A, CAP_B};
        clear_sticky();
        ring = '{2'b00, 2'b10, 2'b11, 2'b01};

        for (int i = 0; i < 41; i++) begin
            vt[i].a = 2'b00; vt[i].b = 2'b00;
            vt[i].cnt = (i < 7) ? 0 : (i < 14) ? 1 : (i < 33) ? 0 : 2;
            vt[i].ent = 2'b00; vt[i].ex = 2'b00; vt[i].er = 2'b00;
        end
        vt[1].a  = 2'b01;                    // lane 0 entry 10,11,01,00
        vt[2].a  = 2'b01; vt[2].b  = 2'b01;
        vt[3].b  = 2'b01;
        vt[6].ent = 2'b01;
        vt[8].b  = 2'b01;                    // lane 0 exit 01,11,10,00
        vt[9].a  = 2'b01; vt[9].b  = 2'b01;
        vt[10].a = 2'b01;
        vt[13].ex = 2'b01;
        vt[15].a = 2'b01;                    // illegal 10 -> 01
        vt[16].b = 2'b01;
        vt[18].er = 2'b01;
        vt[20].a = 2'b01;                    // back-out 10,11,10,00
        vt[21].a = 2'b01; vt[21].b = 2'b01;
        vt[22].a = 2'b01;
        vt[27].a = 2'b11;                    // both lanes enter together
        vt[28].a = 2'b11; vt[28].b = 2'b11;
        vt[29].b = 2'b11;
        vt[32].ent = 2'b11;
        vt[34].a = 2'b01; vt[34].b = 2'b10;  // lane 0 entry with lane 1 exit
        vt[35].a = 2'b11; vt[35].b = 2'b11;
        vt[36].a = 2'b10; vt[36].b = 2'b01;
        vt[39].ent = 2'b01; vt[39].ex = 2'b10;

        reset = 1'b1;
        apply(2'b00, 2'b00, 3);
        check("reset_state", {6'b0, 16'(cnt_a), full_a, empty_a, ovf_a, unf_a, ent_a, ex_a, err_a},
              {6'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0});
        reset = 1'b0;

        for (int i = 0; i < 41; i++) begin
            apply(vt[i].a, vt[i].b, 1);
            check($sformatf("vec_%0d", i), {14'b0, 10'(cnt_a), empty_a, 1'b0, ent_a, ex_a, err_a},
                  {14'b0, 10'(vt[i].cnt), (vt[i].cnt == 0), 1'b0, vt[i].ent, vt[i].ex, vt[i].er});
        end

        // Biased random walk around the beam ring, checked against the model
        for (int l = 0; l < LANES; l++) begin ri[l] = 0; pref[l] = 1; end
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < LANES; l++) begin
                if ($urandom_range(0, 19) == 0) pref[l] = -pref[l];
                rn = $urandom_range(0, 9);
                if (rn >= 5 && rn <= 7)  ri[l] = (ri[l] + pref[l] + 4) % 4;
                else if (rn == 8)        ri[l] = (ri[l] - pref[l] + 4) % 4;
                else if (rn == 9)        ri[l] = $urandom_range(0, 3);
                a_in[l] = ring[ri[l]][1];
                b_in[l] = ring[ri[l]][0];
            end
            reset = ($urandom_range(0, 799) == 0);
            step();
        end

        // Capacity clamp on the CAPACITY=3 instance
        reset = 1'b1;
        apply(2'b00, 2'b00, 2);
        reset = 1'b0;
        apply(2'b00, 2'b00, 2);
        repeat (3) do_entry0();
        check("cap3_full", 32'({cnt_b, full_b}), 32'({2'd3, 1'b1}));
        check("cap99_three", 32'(cnt_a), 32'd3);
        clear_sticky();
        do_both();
        check("full_netted", 32'({cnt_b, full_b, st_ovf_b}), 32'({2'd3, 1'b1, 1'b0}));
        clear_sticky();
        do_entry0();
        check("ovf_pulse", 32'({st_ovf_b, cnt_b}), 32'({1'b1, 2'd3}));
        check("cap99_no_ovf", 32'({st_ovf_a, cnt_a}), 32'({1'b0, 7'd4}));
        reset = 1'b1;
        apply(2'b00, 2'b00, 1);
        reset = 1'b0;
        apply(2'b00, 2'b00, 2);
        clear_sticky();
        do_exit0();
        check("unf_pulse", 32'({st_unf_a, st_unf_b, cnt_a, cnt_b}), 32'({1'b1, 1'b1, 7'd0, 2'd0}));

        // Reset in the middle of an entry, released with 11 still applied
        do_entry0();
        apply(2'b01, 2'b00, 1);
        apply(2'b01, 2'b01, 4);
        reset = 1'b1;
        step();
        check("rst_mid", {6'b0, 16'(cnt_a), full_a, empty_a, ovf_a, unf_a, ent_a, ex_a, err_a},
              {6'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0});
        reset = 1'b0;
        clear_sticky();
        apply(2'b01, 2'b01, 6);
        check("rst_release_err", 32'({st_err_a, st_ent_a}), 32'({2'b01, 2'b00}));
        apply(2'b00, 2'b00, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parking_lot_occupancy.md
# parking_lot_occupancy

Multi-lane parking-lot occupancy tracker for the Nexys board design. Each of `LANES` gates carries two beam sensors, A (outer) and B (inner). A per-lane direction FSM decodes each sensor pair into entry and exit events. A shared saturating counter holds the current occupancy against a parametrised capacity. The block drives the existing seven-segment display path through `count`, and drives status LEDs through `full`, `empty` and the error pulses.

## Interface
- `LANES`, 2, number of gates (1–8)
- `CAPACITY`, 99, maximum occupancy (1–9999)
- `CNT_W`, `$clog2(CAPACITY+1)`, counter width (derived; do not override)
- `CLK100MHZ`  in  1  system clock, 100 MHz
- `reset`  in  1  synchronous, active-high reset
- `A`  in  LANES  outer sensor per lane, asynchronous, 1 = beam blocked
- `B`  in  LANES  inner sensor per lane, asynchronous, 1 = beam blocked
- `count`  out  CNT_W  current occupancy, binary
- `full`  out  1  high when `count == CAPACITY`
- `empty`  out  1  high when `count == 0`
- `entry_pulse`  out  LANES  one-cycle pulse per completed entry
- `exit_pulse`  out  LANES  one-cycle pulse per completed exit
- `seq_err`  out  LANES  one-cycle pulse on an illegal sensor jump
- `ovf`  out  1  one-cycle pulse when entries were dropped at capacity
- `unf`  out  1  one-cycle pulse when exits were dropped at zero

## Operation
- **Input synchronisers.** Each A and B bit passes through its own two-flop synchroniser. All decoding uses the synchronised pair `{a,b}`.
- **Lane FSM states.** IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR.
- **Entry path.**
  - IDLE on 10 → EN1.
  - EN1 on 11 → EN2.
  - EN2 on 01 → EN3.
  - EN3 on 00 → IDLE, and asserts `entry_pulse`.
- **Exit path.**
  - IDLE on 01 → EX1.
  - EX1 on 11 → EX2.
  - EX2 on 10 → EX3.
  - EX3 on 00 → IDLE, and asserts `exit_pulse`.
- **Reversal (vehicle backs out).**
  - EN3 on 11 → EN2.
  - EN2 on 10 → EN1.
  - EN1 on 00 → IDLE, no event.
  - The exit path reverses the same way: EX3 → EX2 → EX1 → IDLE.
- **Unchanged input.** Any state holds.
- **Illegal jumps.** These are 00↔11 and 10↔01 in any state, plus any code not listed above. The lane goes to ERR and pulses `seq_err` for one cycle. ERR holds until `{a,b}==00`, then goes to IDLE with no event.
- **Counter update.** `net = popcount(entry_pulse) - popcount(exit_pulse)`, computed as a signed value of width CNT_W+4.
  - `count_next = clamp(count + net, 0, CAPACITY)`.
  - `ovf` pulses if the unclamped sum exceeds CAPACITY.
  - `unf` pulses if the unclamped sum is below 0.
- **Simultaneous events.** Any mix of events across lanes in one cycle is netted before clamping. No event is lost unless clamping applies.
  - Example: full, one entry and one exit in the same cycle → `count` unchanged, no `ovf`.
- **Full gate.** Entries are never blocked at the gate. `full` is advisory only.
- **Reset values (all outputs and state).**
  - Every FSM is in IDLE.
  - Synchroniser flops are 0.
  - `count=0`, `empty=1`, `full=0`.
  - All pulse outputs are 0.

## Timing
- Reset is sampled on the `CLK100MHZ` rising edge. It takes effect at that edge and overrides all other activity, including in-flight sequences. After reset is released, a lane that sees a non-00 pair enters the path matching that code, or ERR if the code is 11.
- Sensor pair stable before edge n → synchronised value visible after edge n+1 → FSM transition and event pulse registered at edge n+2.
- `count`, `full`, `empty`, `ovf` and `unf` are registered at edge n+3.
- End-to-end latency is 3 cycles from sensor sampling to `count`.
- `full` and `empty` are registered from `count_next` and are never a cycle behind `count`.
- Pulses are exactly one cycle wide. A lane can produce at most one event every 4 cycles.

## Structure
- Package `parking_pkg` holds:
  - the lane state enum, in the order IDLE, EN1–EN3, EX1–EX3, ERR;
  - the sensor code constants `S_CLR=2'b00`, `S_A=2'b10`, `S_AB=2'b11`, `S_B=2'b01`.
- Sub-module `gate_direction_fsm` contains one lane: synchroniser, FSM, and the entry/exit/err pulse outputs.
  - The top level instantiates it `LANES` times in a generate loop.
  - The top level contains the popcount/net adder, the clamp logic and the counter.

## Test plan
- **Entry and exit, lane 0, LANES=2, CAPACITY=99.** Lane 0 sequence 00,10,11,01,00 → one `entry_pulse[0]`, `count` 0→1, `empty` falls. Then 01,11,10,00 → `exit_pulse[0]`, `count`=0, `empty`=1.
- **Illegal jump and reversal.** Lane 0 sequence 10→01 → `seq_err[0]` pulse, lane in ERR, no count change; 00 returns it to IDLE. Then 10,11,10,00 (back-out) → no pulse, `count` unchanged.
- **Simultaneous events.** Both lanes complete an entry in the same cycle → `count` +2 in one step. Lane 0 entry together with lane 1 exit → `count` unchanged.
- **Capacity clamp, CAPACITY=3.** Preload to 3 via entries, `full`=1. A further entry → `ovf` pulse, `count` stays 3. An exit at `count`=0 → `unf` pulse, `count` stays 0.
- **Mid-sequence reset.** Lane 0 held in EN2 (11); assert `reset` for one cycle, then release with 11 still applied → all outputs at reset values, `count`=0. On release the lane enters ERR and pulses `seq_err`, with no spurious `entry_pulse`.
